hazard_scheduler: RTL

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler_pkg.sv | 32 +++
 rtl/hazard_match.sv | 27 ++
 rtl/hazard_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scheduler_pkg
//  Purpose  : Shared definitions for the pipeline hazard scheduler:
//             forwarding select codes, the register-zero number and the
//             shadow pipeline record layout.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_scheduler_pkg;

    localparam int          REG_W    = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // EX operand source selects
    localparam logic [1:0]  FWD_REG  = 2'd0;
    localparam logic [1:0]  FWD_MEM  = 2'd1;
    localparam logic [1:0]  FWD_WB   = 2'd2;

    // Shadow copy of the hazard-relevant fields of one pipeline stage
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
    } stage_rec_t;

endpackage : hazard_scheduler_pkg
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_match
//  Purpose  : Compares one producer record against one consumer source
//             register. A match needs a valid producer that writes a
//             non-zero register equal to a source the consumer really reads.
//  Ports    : rec_valid, rec_reg_write, rec_dest - producer record fields
//             src, src_used                       - consumer source operand
//             match                               - dependency detected
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_match
    import hazard_scheduler_pkg::*;
(
    input  logic             rec_valid,
    input  logic             rec_reg_write,
    input  logic [REG_W-1:0] rec_dest,
    input  logic [REG_W-1:0] src,
    input  logic             src_used,
    output logic             match
);

    assign match = rec_valid && rec_reg_write && src_used &&
                   (rec_dest != REG_ZERO) && (rec_dest == src);

endmodule : hazard_match
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scheduler
//  Purpose  : Hazard detection / forwarding control for a 5-stage pipeline.
//             Keeps shadow records of EX, MEM and WB, produces stall and
//             flush controls for IF/ID and ID/EX, EX operand forwarding
//             selects and a saturating stall-cycle counter.
//  Config   : HAZARD_FORWARDING_EN - defined: forwarding with load-use and
//             JR stalls only; undefined: no forwarding, any EX/MEM
//             dependency of the ID instruction stalls.
//  Ports    : clk, reset (async, active high)
//             id_*          - decoded ID-stage instruction
//             ex_redirect   - taken branch resolved in EX
//             stall_if_id, flush_if_id, flush_id_ex - pipeline controls
//             fwd_a_sel, fwd_b_sel - EX operand source (0 reg, 1 MEM, 2 WB)
//             stall_count   - saturating number of stall cycles
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_jump,
    input  logic             id_jump_reg,
    input  logic             ex_redirect,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    stage_rec_t       r_ex, r_mem, r_wb;
    stage_rec_t       w_id_rec;
    logic [CNT_W-1:0] r_stall_count;

    logic [1:0][REG_W-1:0] w_id_src;
    logic [1:0]            w_id_used;
    logic [1:0]            w_ex_id_m;
    logic [1:0]            w_mem_id_m;
    logic                  w_jr_hazard;
    logic                  w_hazard;
    logic [1:0][1:0]       w_fwd;

    assign w_id_rec = '{valid:      id_valid,
                        dest:       id_dest,
                        reg_write:  id_reg_write,
                        mem_to_reg: id_mem_to_reg,
                        rs:         id_rs,
                        rt:         id_rt,
                        uses_rs:    id_uses_rs,
                        uses_rt:    id_uses_rt};

    // Index 0 is rs, index 1 is rt; an invalid ID slot reads nothing
    assign w_id_src  = {id_rt, id_rs};
    assign w_id_used = {id_valid & id_uses_rt, id_valid & id_uses_rs};

`ifdef HAZARD_FORWARDING_EN
    logic [1:0][REG_W-1:0] w_ex_src;
    logic [1:0]            w_ex_used;
    logic [1:0]            w_mem_ex_m;
    logic [1:0]            w_wb_ex_m;

    assign w_ex_src  = {r_ex.rt, r_ex.rs};
    assign w_ex_used = {r_ex.valid & r_ex.uses_rt, r_ex.valid & r_ex.uses_rs};
`endif

    for (genvar s = 0; s < 2; s++) begin : g_src
        hazard_match u_ex_id (
            .rec_valid     (r_ex.valid),
            .rec_reg_write (r_ex.reg_write),
            .rec_dest      (r_ex.dest),
            .src           (w_id_src[s]),
            .src_used      (w_id_used[s]),
            .match         (w_ex_id_m[s])
        );
        hazard_match u_mem_id (
            .rec_valid     (r_mem.valid),
            .rec_reg_write (r_mem.reg_write),
            .rec_dest      (r_mem.dest),
            .src           (w_id_src[s]),
            .src_used      (w_id_used[s]),
            .match         (w_mem_id_m[s])
        );
`ifdef HAZARD_FORWARDING_EN
        hazard_match u_mem_ex (
            .rec_valid     (r_mem.valid),
            .rec_reg_write (r_mem.reg_write),
            .rec_dest      (r_mem.dest),
            .src           (w_ex_src[s]),
            .src_used      (w_ex_used[s]),
            .match         (w_mem_ex_m[s])
        );
        hazard_match u_wb_ex (
            .rec_valid     (r_wb.valid),
            .rec_reg_write (r_wb.reg_write),
            .rec_dest      (r_wb.dest),
            .src           (w_ex_src[s]),
            .src_used      (w_ex_used[s]),
            .match         (w_wb_ex_m[s])
        );
`endif
    end

    // JR reads its target in ID, so nothing can be forwarded to it: wait
    // until the producer has left both EX and MEM.
    assign w_jr_hazard = id_jump_reg & (w_ex_id_m[0] | w_mem_id_m[0]);

`ifdef HAZARD_FORWARDING_EN
    assign w_hazard = (r_ex.mem_to_reg & (|w_ex_id_m)) | w_jr_hazard;
`else
    // Regfile writes in the first half-cycle, so a WB producer is harmless
    assign w_hazard = (|w_ex_id_m) | (|w_mem_id_m) | w_jr_hazard;
`endif

    // Redirect wins over any stall or jump in the same cycle
    always_comb begin
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!reset) begin
            if (ex_redirect) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (w_hazard) begin
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (id_valid && (id_jump || id_jump_reg)) begin
                flush_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        w_fwd = {FWD_REG, FWD_REG};
`ifdef HAZARD_FORWARDING_EN
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                // A load result is not ready in MEM; the load-use stall
                // guarantees that case never needs a MEM forward.
                if (w_mem_ex_m[s] && !r_mem.mem_to_reg) begin
                    w_fwd[s] = FWD_MEM;
                end else if (w_wb_ex_m[s]) begin
                    w_fwd[s] = FWD_WB;
                end
            end
        end
`endif
    end

    assign fwd_a_sel = w_fwd[0];
    assign fwd_b_sel = w_fwd[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= flush_id_ex ? '0 : w_id_rec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (stall_if_id && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

    // Record fields not consumed in every build configuration
    logic w_unused_rec;
    assign w_unused_rec = ^{r_ex, r_mem, r_wb, w_mem_id_m};

endmodule : hazard_scheduler
`default_nettype wire
